fir_decim_buffer: RTL and testbench

//  Downstream stage of fir_filter: consumes filtered sample stream y, keeps every

---
 rtl/fir_pkg.sv | 11 +
 rtl/fir_sync_fifo.sv | 87 ++++++++
 rtl/fir_decim_buffer.sv | 94 +++++++++
 tb/tb_fir_decim_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and sample type for the fir_filter chain and its downstream
// stages.
package fir_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int DECIM_DEF = 4;
  localparam int DEPTH_DEF = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through head.
// The occupancy count tells full apart from empty.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              ready_i,
  output logic              pop_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LW-1:0]     level_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              pop_s;

  // Next-state pointers, occupancy and the head value to present next cycle.
  always_comb begin
    pop_s    = valid_q & ready_i;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    case ({push_i, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    valid_d = (level_d != LW'(0));
    // The new head may be the word being written right now.
    if (level_d == LW'(0)) begin
      head_d = head_q;
    end else if (push_i && (rd_ptr_d == wr_ptr_q)) begin
      head_d = wr_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Pointer, occupancy and head registers; clear keeps the last head word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  // Storage array, written only when the caller has accepted the push.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign pop_o   = pop_s;
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = ~valid_q;
  assign level_o = level_q;
  assign head_o  = head_q;

endmodule

// File: rtl/fir_decim_buffer.sv
// Keeps every DECIM-th valid sample from fir_filter and buffers it for a
// valid/ready consumer. Define FIR_DECIM_DROP_CNT_EN to add the drop_cnt output.
module fir_decim_buffer
  import fir_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DECIM  = DECIM_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int LW    = $clog2(DEPTH) + 1,
  localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LW-1:0]     level,
  output logic              overflow
`ifdef FIR_DECIM_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  logic [PW-1:0] phase_q, phase_d;
  logic          overflow_q;
  logic          keep_s, push_s, drop_s, pop_s, full_s, empty_s;

  // Keep/drop decision; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    keep_s = in_valid & ~flush & (phase_q == PW'(0));
    push_s = keep_s & (~full_s | pop_s);
    drop_s = keep_s & ~push_s;
    if (flush) begin
      phase_d = '0;
    end else if (in_valid) begin
      phase_d = (phase_q == PW'(DECIM - 1)) ? PW'(0) : phase_q + PW'(1);
    end else begin
      phase_d = phase_q;
    end
  end

  // Decimation phase and sticky overflow; flush never clears the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_q | drop_s;
    end
  end

`ifdef FIR_DECIM_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of dropped kept samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= 16'h0000;
    end else if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'h0001;
    end else begin
      drop_cnt_q <= drop_cnt_q;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  fir_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (flush),
    .push_i    (push_s),
    .wr_data_i (in_data),
    .ready_i   (out_ready),
    .pop_o     (pop_s),
    .full_o    (full_s),
    .empty_o   (empty_s),
    .level_o   (level),
    .head_o    (out_data)
  );

  assign out_valid = ~empty_s;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed bench for fir_decim_buffer: a DECIM=4 instance for the main tests
// and a DECIM=1 instance for the pass-through latency test.
module tb_fir_decim_buffer;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] in_data;

  logic        out_valid0, overflow0, out_valid1, overflow1;
  logic [15:0] out_data0, out_data1;
  logic [3:0]  level0, level1;
`ifdef FIR_DECIM_DROP_CNT_EN
  logic [15:0] drop_cnt0, drop_cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] got_q [$];

  always #5 clk = ~clk;

  fir_decim_buffer #(.DATA_W(16), .DECIM(4), .DEPTH(8)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .level(level0), .overflow(overflow0)
`ifdef FIR_DECIM_DROP_CNT_EN
    , .drop_cnt(drop_cnt0)
`endif
  );

  fir_decim_buffer #(.DATA_W(16), .DECIM(1), .DEPTH(8)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .level(level1), .overflow(overflow1)
`ifdef FIR_DECIM_DROP_CNT_EN
    , .drop_cnt(drop_cnt1)
`endif
  );

  // Record every word the consumer accepts from the DECIM=4 instance.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid0 && out_ready) got_q.push_back(out_data0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(first + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Expected stream: first, first+4, ... (n words), optionally one extra word.
  task automatic check_stream(input string tag, input int first, input int n,
                              input bit has_extra, input int extra);
    int exp_n;
    int exp_v;
    exp_n = has_extra ? n + 1 : n;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      exp_v = (i < n) ? first + 4 * i : extra;
      if (i < got_q.size()) check(tag, 32'(got_q[i]), 32'(exp_v));
      else check(tag, 32'hFFFF_FFFF, 32'(exp_v));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid0"}, 32'(out_valid0), 32'd0);
    check({tag, "_data0"},  32'(out_data0),  32'd0);
    check({tag, "_level0"}, 32'(level0),     32'd0);
    check({tag, "_ovf0"},   32'(overflow0),  32'd0);
    check({tag, "_valid1"}, 32'(out_valid1), 32'd0);
    check({tag, "_level1"}, 32'(level1),     32'd0);
`ifdef FIR_DECIM_DROP_CNT_EN
    check({tag, "_drop0"},  32'(drop_cnt0),  32'd0);
`endif
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 16'h0000;
    tick(); tick();
    check_reset_state("reset");
    reset = 1'b0;

    // 1: continuous stream, every fourth sample out
    got_q.delete();
    out_ready = 1'b1;
    feed(1, 12);
    repeat (4) tick();
    check_stream("t1_stream", 1, 3, 1'b0, 0);
    check("t1_ovf", 32'(overflow0), 32'd0);
    check("t1_level", 32'(level0), 32'd0);

    // 2: gaps between valid samples do not advance the phase
    flush = 1'b1; tick(); flush = 1'b0;
    got_q.delete();
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = 16'(101 + i); tick();
      in_valid = 1'b0; in_data = 16'hDEAD;     tick();
    end
    repeat (3) tick();
    check_stream("t2_gaps", 101, 3, 1'b0, 0);

    // 3: nine kept samples into an eight-deep FIFO with no consumer
    got_q.delete();
    out_ready = 1'b0;
    feed(1, 36);
    check("t3_level", 32'(level0), 32'd8);
    check("t3_ovf", 32'(overflow0), 32'd1);
    check("t3_valid", 32'(out_valid0), 32'd1);
    check("t3_head", 32'(out_data0), 32'd1);
`ifdef FIR_DECIM_DROP_CNT_EN
    check("t3_drop", 32'(drop_cnt0), 32'd1);
`endif
    tick();
    check("t3_head_stable", 32'(out_data0), 32'd1);
    out_ready = 1'b1;
    repeat (10) tick();
    check_stream("t3_drain", 1, 8, 1'b0, 0);
    check("t3_level_empty", 32'(level0), 32'd0);
    check("t3_valid_empty", 32'(out_valid0), 32'd0);
    check("t3_data_hold", 32'(out_data0), 32'd29);

    // 5: flush with three buffered, sample in the flush cycle ignored
    out_ready = 1'b0;
    feed(1, 9);
    check("t5_level_pre", 32'(level0), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd77;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_valid", 32'(out_valid0), 32'd0);
    check("t5_level", 32'(level0), 32'd0);
    check("t5_ovf_kept", 32'(overflow0), 32'd1);
`ifdef FIR_DECIM_DROP_CNT_EN
    check("t5_drop_kept", 32'(drop_cnt0), 32'd1);
`endif
    in_valid = 1'b1; in_data = 16'd55;
    tick();
    in_valid = 1'b0;
    check("t5_next_level", 32'(level0), 32'd1);
    check("t5_next_valid", 32'(out_valid0), 32'd1);
    check("t5_next_data", 32'(out_data0), 32'd55);

    // 6a: reset in mid-stream with content buffered
    in_valid = 1'b1; in_data = 16'd66; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check_reset_state("t6_reset");

    // 4: full FIFO accepts a kept sample when the head pops in the same cycle
    got_q.delete();
    out_ready = 1'b0;
    feed(1, 32);
    check("t4_level_full", 32'(level0), 32'd8);
    check("t4_ovf_pre", 32'(overflow0), 32'd0);
    in_valid = 1'b1; in_data = 16'd200; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t4_level", 32'(level0), 32'd8);
    check("t4_ovf", 32'(overflow0), 32'd0);
    check("t4_head", 32'(out_data0), 32'd5);
    repeat (12) tick();
    check_stream("t4_drain", 1, 8, 1'b1, 200);

    // 6b: DECIM=1 passes every sample with one cycle of latency
    reset = 1'b1; tick(); reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 16'(300 + k);
      tick();
      check("t6_d1_valid", 32'(out_valid1), 32'd1);
      check("t6_d1_data", 32'(out_data1), 32'(300 + k));
      check("t6_d1_level", 32'(level1), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("t6_d1_empty", 32'(out_valid1), 32'd0);
    check("t6_d1_hold", 32'(out_data1), 32'd302);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
